// File: rtl/gate_check_pkg.sv
// Shared types and sizing helpers for the gate truth-table checker family.
package gate_check_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Number of input vectors for an n-input gate.
    function automatic int vec_count(input int n);
        return 1 << n;
    endfunction

    // Mismatch counter must hold the full vector count, hence n+1 bits.
    function automatic int err_width(input int n);
        return n + 1;
    endfunction

    // Settle counter must be able to hold the value SETTLE_CYCLES.
    function automatic int cnt_width(input int settle);
        return (settle < 1) ? 1 : $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Settle-window timer: load clears the count, enable advances it, and tc
// pulses during the last cycle of a SETTLE_CYCLES-long enabled window.
module settle_timer #(
    parameter int SETTLE_CYCLES = 10,
    parameter int CNT_W         = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Count enabled cycles since the last load.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values.
        if (reset || load) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = enable && !load && (cnt == LAST);

endmodule

// File: rtl/gate_truth_checker.sv
// Drives every input vector of a small combinational gate, samples its output
// after a settle window and compares it against TRUTH_TABLE.  The sample taken
// in CHECK is folded into the results on the following edge, which is also the
// edge done rises after the last vector, so pass is valid in the first DONE cycle.
module gate_truth_checker
    import gate_check_pkg::*;
#(
    parameter int                                 N_INPUTS      = 2,
    parameter int                                 SETTLE_CYCLES = 10,
    parameter logic [vec_count(N_INPUTS)-1:0]     TRUTH_TABLE   = 4'b1110
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic [N_INPUTS-1:0]              stim,
    input  logic                             dut_out,
    output logic                             busy,
    output logic                             done,
    output logic                             pass,
    output logic [err_width(N_INPUTS)-1:0]   err_count,
    output logic                             first_fail_valid,
    output logic [N_INPUTS-1:0]              first_fail_vec
);

    localparam int                  EW       = err_width(N_INPUTS);
    localparam int                  CW       = cnt_width(SETTLE_CYCLES);
    localparam logic [N_INPUTS-1:0] LAST_VEC = N_INPUTS'(vec_count(N_INPUTS) - 1);

    state_t              state;
    logic [N_INPUTS-1:0] vec;

    // Sample captured in CHECK, accumulated on the next edge.
    logic                sample_pending;
    logic                sample_bad;
    logic [N_INPUTS-1:0] sample_vec;

    logic                start_ok;
    logic                settle_tc;
    logic                mismatch;

    logic [EW-1:0]       err_next;
    logic                ffv_next;
    logic [N_INPUTS-1:0] ffvec_next;

    assign stim     = vec;
    assign start_ok = start && ((state == IDLE) || (state == DONE));

    // Case inequality so an X/Z from the gate under test counts as a failure
    // in simulation; in hardware it reduces to an ordinary inequality.
    assign mismatch = (dut_out !== TRUTH_TABLE[vec]);

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (CW)
    ) u_settle_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (start_ok || (state == CHECK)),
        .enable (state == DRIVE),
        .tc     (settle_tc)
    );

    // Result values after folding in the pending sample, if any.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        err_next   = err_count;
        ffv_next   = first_fail_valid;
        ffvec_next = first_fail_vec;
        if (sample_pending && sample_bad) begin
            err_next = err_count + EW'(1);
            if (!first_fail_valid) begin
                ffv_next   = 1'b1;
                ffvec_next = sample_vec;
            end
        end
    end

    // Sequencer FSM with registered status and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            vec              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            sample_pending   <= 1'b0;
            sample_bad       <= 1'b0;
            sample_vec       <= '0;
        end else begin
            err_count        <= err_next;
            first_fail_valid <= ffv_next;
            first_fail_vec   <= ffvec_next;
            sample_pending   <= 1'b0;
            done             <= (state == DONE);
            pass             <= (state == DONE) && (err_next == '0);

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state            <= DRIVE;
                        vec              <= '0;
                        busy             <= 1'b1;
                        pass             <= 1'b0;
                        err_count        <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
                    end
                end
                DRIVE: begin
                    if (settle_tc) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    sample_pending <= 1'b1;
                    sample_bad     <= mismatch;
                    sample_vec     <= vec;
                    // Terminal compare before incrementing keeps stim from wrapping.
                    if (vec == LAST_VEC) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end else begin
                        vec   <= vec + N_INPUTS'(1);
                        state <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboard bench for gate_truth_checker: a 2-input instance with default
// parameters and a 3-input XOR instance with a one-cycle settle window.
module tb_gate_truth_checker;

    typedef struct {
        int err;
        int ffv;
        int ffvec;
        int pass;
        int done_cyc;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       start_a;
    logic       start_b;

    logic [1:0] stim_a;
    logic       dut_out_a;
    logic       busy_a, done_a, pass_a, ffv_a;
    logic [2:0] err_a;
    logic [1:0] ffvec_a;

    logic [2:0] stim_b;
    logic       dut_out_b;
    logic       busy_b, done_b, pass_b, ffv_b;
    logic [3:0] err_b;
    logic [2:0] ffvec_b;

    int   mode_a;
    logic inv_b;
    int   cyc;
    int   total;
    int   bad;
    logic prev_a;
    logic prev_b;

    exp_t qa[$];
    exp_t qb[$];

    gate_truth_checker u_dut_a (
        .clk              (clk),
        .reset            (reset),
        .start            (start_a),
        .stim             (stim_a),
        .dut_out          (dut_out_a),
        .busy             (busy_a),
        .done             (done_a),
        .pass             (pass_a),
        .err_count        (err_a),
        .first_fail_valid (ffv_a),
        .first_fail_vec   (ffvec_a)
    );

    gate_truth_checker #(
        .N_INPUTS      (3),
        .SETTLE_CYCLES (1),
        .TRUTH_TABLE   (8'b10010110)
    ) u_dut_b (
        .clk              (clk),
        .reset            (reset),
        .start            (start_b),
        .stim             (stim_b),
        .dut_out          (dut_out_b),
        .busy             (busy_b),
        .done             (done_b),
        .pass             (pass_b),
        .err_count        (err_b),
        .first_fail_valid (ffv_b),
        .first_fail_vec   (ffvec_b)
    );

    // Gates under test: 0 = OR (correct), 1 = AND, 2 = XOR.
    always_comb begin
        case (mode_a)
            1:       dut_out_a = stim_a[0] & stim_a[1];
            2:       dut_out_a = stim_a[0] ^ stim_a[1];
            default: dut_out_a = stim_a[0] | stim_a[1];
        endcase
    end

    assign dut_out_b = (^stim_b) ^ inv_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic check_zero(input string tag, input int s, input logic bz, input logic dn,
                              input logic ps, input int er, input logic fv, input int fvec);
        check({tag, "_stim"}, s, 0);
        check({tag, "_busy"}, bz, 0);
        check({tag, "_done"}, dn, 0);
        check({tag, "_pass"}, ps, 0);
        check({tag, "_err"}, er, 0);
        check({tag, "_ffv"}, fv, 0);
        check({tag, "_ffvec"}, fvec, 0);
    endtask

    // Pulse start for one edge; t is the cycle number of the sampling edge.
    task automatic pulse(input int which, output int t);
        @(negedge clk);
        if (which == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk);
        #1;
        t = cyc;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic push_a(input int e, input int fv, input int fvec, input int p, input int dc);
        exp_t x;
        x.err = e; x.ffv = fv; x.ffvec = fvec; x.pass = p; x.done_cyc = dc;
        qa.push_back(x);
    endtask

    task automatic push_b(input int e, input int fv, input int fvec, input int p, input int dc);
        exp_t x;
        x.err = e; x.ffv = fv; x.ffvec = fvec; x.pass = p; x.done_cyc = dc;
        qb.push_back(x);
    endtask

    task automatic drain_a();
        for (int i = 0; i < 120 && qa.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #2;
        check("a_drain", qa.size(), 0);
    endtask

    task automatic drain_b();
        for (int i = 0; i < 60 && qb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #2;
        check("b_drain", qb.size(), 0);
    endtask

    // Monitor for instance A: compare results whenever done rises.
    initial begin
        exp_t e;
        prev_a = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (done_a && !prev_a) begin
                check("a_expected_run", (qa.size() > 0), 1);
                if (qa.size() > 0) begin
                    e = qa.pop_front();
                    check("a_done_cycle", cyc, e.done_cyc);
                    check("a_err_count", err_a, e.err);
                    check("a_ffv", ffv_a, e.ffv);
                    check("a_ffvec", ffvec_a, e.ffvec);
                    check("a_pass", pass_a, e.pass);
                    check("a_stim_hold", stim_a, 3);
                    check("a_busy_done", busy_a, 0);
                end
            end
            prev_a = done_a;
        end
    end

    // Monitor for instance B.
    initial begin
        exp_t e;
        prev_b = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (done_b && !prev_b) begin
                check("b_expected_run", (qb.size() > 0), 1);
                if (qb.size() > 0) begin
                    e = qb.pop_front();
                    check("b_done_cycle", cyc, e.done_cyc);
                    check("b_err_count", err_b, e.err);
                    check("b_ffv", ffv_b, e.ffv);
                    check("b_ffvec", ffvec_b, e.ffvec);
                    check("b_pass", pass_b, e.pass);
                    check("b_stim_hold", stim_b, 7);
                end
            end
            prev_b = done_b;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 20000", cyc);
        $fatal(1);
    end

    initial begin
        int t;
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        mode_a  = 0;
        inv_b   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_zero("a_reset", stim_a, busy_a, done_a, pass_a, err_a, ffv_a, ffvec_a);
        check_zero("b_reset", stim_b, busy_b, done_b, pass_b, err_b, ffv_b, ffvec_b);

        // Correct OR; stim stepping every 11 cycles; stray start at t+20 ignored.
        pulse(0, t);
        push_a(0, 0, 0, 1, t + 45);
        check("a_stim_k0", stim_a, 0);
        for (int k = 1; k <= 44; k++) begin
            @(posedge clk);
            #1;
            check("a_stim_step", stim_a, (k / 11 > 3) ? 3 : k / 11);
            if (k == 19) start_a = 1'b1;
            if (k == 20) begin
                start_a = 1'b0;
                check("a_busy_mid", busy_a, 1);
            end
        end
        check("a_busy_after_last", busy_a, 0);
        check("a_done_not_yet", done_a, 0);
        drain_a();

        // AND gate: mismatches at vectors 1 and 2.
        mode_a = 1;
        pulse(0, t);
        push_a(2, 1, 1, 0, t + 45);
        drain_a();

        // Restart from a failing DONE with a correct gate.
        mode_a = 0;
        pulse(0, t);
        check("a_restart_err_clr", err_a, 0);
        check("a_restart_ffv_clr", ffv_a, 0);
        check("a_restart_done_hold", done_a, 1);
        push_a(0, 0, 0, 1, t + 45);
        @(posedge clk);
        #1;
        check("a_restart_done_drop", done_a, 0);
        drain_a();

        // XOR gate: only the last vector mismatches.
        mode_a = 2;
        pulse(0, t);
        push_a(1, 1, 3, 0, t + 45);
        drain_a();

        // Reset at t+25 of an AND run aborts it with nothing retained.
        mode_a = 1;
        pulse(0, t);
        repeat (24) @(posedge clk);
        #1;
        check("a_pre_abort_err", err_a, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_zero("a_abort", stim_a, busy_a, done_a, pass_a, err_a, ffv_a, ffvec_a);
        mode_a = 0;
        pulse(0, t);
        push_a(0, 0, 0, 1, t + 45);
        drain_a();

        // 3-input XOR, one settle cycle: correct, then inverted output.
        inv_b = 1'b0;
        pulse(1, t);
        push_b(0, 0, 0, 1, t + 17);
        drain_b();
        inv_b = 1'b1;
        pulse(1, t);
        push_b(8, 1, 0, 0, t + 17);
        drain_b();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_truth_checker.md
Name: gate_truth_checker

Overview:
- Synthesizable self-checking stimulus/response engine for small combinational gates.
- Drives every input combination of an N-input DUT gate and samples the DUT output after a settle delay.
- Compares each sample against a parameterized truth table, counting mismatches and capturing the first failing vector.
- Reports pass/fail for the on-chip gate checks in the learning-circuits suite.

Parameters:
N_INPUTS, 2, number of DUT inputs (1..8); vectors = 2**N_INPUTS
SETTLE_CYCLES, 10, cycles each vector is held before sampling (>=1)
TRUTH_TABLE, 4'b1110 (OR), expected output; bit k = expected DUT output for stim == k; width 2**N_INPUTS

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state
start  input  1  begin a run; sampled only in IDLE or DONE
stim  output  N_INPUTS  vector driven to DUT inputs
dut_out  input  1  DUT output under test
busy  output  1  high in DRIVE/CHECK
done  output  1  high in DONE
pass  output  1  valid when done; 1 iff err_count == 0
err_count  output  N_INPUTS+1  number of mismatching vectors, saturates never needed (max 2**N)
first_fail_valid  output  1  a mismatch has been captured this run
first_fail_vec  output  N_INPUTS  lowest-index failing vector

Behaviour:
- Reset (synchronous, active-high, wins over everything): state=IDLE, stim=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_vec=0, settle counter=0.
- States: IDLE, DRIVE, CHECK, DONE.
- IDLE: start=1 -> DRIVE. At the same edge: vec=0, settle cnt=0, err_count=0, first_fail_valid=0, first_fail_vec=0.
- DRIVE: stim=vec held constant; cnt increments each cycle; after SETTLE_CYCLES cycles in DRIVE -> CHECK.
- CHECK (one cycle):
  - Compare dut_out with TRUTH_TABLE[vec].
  - Mismatch: err_count+=1; if !first_fail_valid, capture first_fail_vec=vec and set first_fail_valid=1.
  - vec == 2**N_INPUTS-1 -> DONE; else vec+=1, cnt=0 -> DRIVE.
- Timing: with start sampled at edge t, the last CHECK is at t + 2**N*(SETTLE_CYCLES+1) and done rises at t + 2**N*(SETTLE_CYCLES+1) + 1. For defaults this is t+45.
- DONE: done=1, pass=(err_count==0), stim holds the last vector, and results stay stable. start=1 restarts exactly as from IDLE (results cleared on the same edge; done drops the next cycle).
- start while busy: ignored; no effect on the run.
- The err_count update in the final CHECK is visible on the same edge done rises, so pass is correct in the first DONE cycle.
- vec is N_INPUTS+1 bits wide internally, or the terminal compare is made before incrementing; stim never wraps to 0 mid-run.
- dut_out of X/Z in simulation counts as a mismatch (case-inequality compare under a sim-only guard).
- Reset mid-run: abort to IDLE next edge, all outputs cleared; no partial results are retained.

Decomposition:
- gate_check_pkg:
  - state_t enum {IDLE, DRIVE, CHECK, DONE}.
  - Localparams/functions for vector count (2**N) and the counter widths err_count (N+1) and settle cnt ($clog2(SETTLE_CYCLES+1)).
- One sub-module: settle_timer (load/enable, terminal-count pulse after SETTLE_CYCLES cycles), reused by later sequential gate benches.

Test Plan:
- Defaults, DUT = correct OR, start pulse at t -> stim steps 0,1,2,3 each held 11 cycles; done=1 at t+45, pass=1, err_count=0, first_fail_valid=0.
- Defaults, DUT = AND (mismatch at stim 1 and 2) -> err_count=2, first_fail_vec=1, first_fail_valid=1, pass=0.
- N_INPUTS=3, SETTLE_CYCLES=1, TRUTH_TABLE=8'b10010110, DUT = 3-input XOR -> done at t+17, pass=1; invert the DUT output -> err_count=8, first_fail_vec=0.
- start pulsed again at t+20 during a run -> ignored; done still at t+45 with unchanged results.
- reset asserted at t+25 for 1 cycle -> IDLE next edge with all outputs 0; a new start runs a full clean pass.
- From DONE with a failing result, swap in a correct DUT and pulse start -> err_count/first_fail_valid cleared on that edge, done low next cycle, final pass=1.
